fetch_sequencer: RTL

Program-counter and launch sequencer that sits directly upstream of the instruction ROM and feeds PgmCtr to the single-cycle core. It implements the core's Start/Ack run handshake. The bench holds Start high during init and drops it to launch. The block steps, branches and halts the PC, raises Ack when the program completes, and provides a cycle count and a watchdog timeout.

---
 rtl/fetch_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Program counter and Start/Ack launch sequencer feeding the instruction ROM.
// Holds the PC at StartAddr while Start is high, runs on Start's falling edge, and stops on Halt or watchdog.
module fetch_sequencer #(
  parameter int unsigned            PC_W       = 10,
  parameter int unsigned            OFF_W      = 6,
  parameter int unsigned            CNT_W      = 16,
  parameter logic [CNT_W-1:0]       MAX_CYCLES = 16'hFFFF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             Halt,
  input  logic             BranchEn,
  input  logic             BranchAbs,
  input  logic [PC_W-1:0]  Target,
  input  logic [OFF_W-1:0] Offset,
  output logic [PC_W-1:0]  PgmCtr,
  output logic             Running,
  output logic             Ack,
  output logic             Timeout,
  output logic [CNT_W-1:0] CycleCount
);

  typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] WD_LAST = MAX_CYCLES - CNT_W'(1);

  state_t            state, state_nxt;
  logic              start_q;
  logic              launch, wd_hit;
  logic [PC_W-1:0]   off_ext;
  logic [PC_W-1:0]   pc_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              run_d, ack_d, to_d;

  assign launch  = (state == HOLD) & start_q & ~Start;
  assign wd_hit  = (MAX_CYCLES != '0) && (CycleCount == WD_LAST);
  assign off_ext = {{(PC_W-OFF_W){Offset[OFF_W-1]}}, Offset};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= Start;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (Start) state_nxt = HOLD;
      HOLD: if (launch) state_nxt = RUN;
      RUN: begin
        if (Start)              state_nxt = HOLD;
        else if (Halt || wd_hit) state_nxt = DONE;
      end
      DONE: if (Start) state_nxt = HOLD;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; Start in RUN is an abort and freezes the counter.
  always_comb begin
    pc_d  = PgmCtr;
    cnt_d = CycleCount;
    run_d = Running;
    ack_d = Ack;
    to_d  = Timeout;
    unique case (state)
      IDLE: ;
      HOLD: begin
        pc_d  = StartAddr;
        ack_d = 1'b0;
        to_d  = 1'b0;
        if (launch) begin
          cnt_d = '0;
          run_d = 1'b1;
        end
      end
      RUN: begin
        if (Start) begin
          run_d = 1'b0;
        end else begin
          cnt_d = CycleCount + CNT_W'(1);
          if (Halt) begin
            run_d = 1'b0;
            ack_d = 1'b1;
          end else if (wd_hit) begin
            run_d = 1'b0;
            ack_d = 1'b1;
            to_d  = 1'b1;
          end else if (BranchEn && BranchAbs) begin
            pc_d = Target;
          end else if (BranchEn) begin
            pc_d = PgmCtr + off_ext;
          end else begin
            pc_d = PgmCtr + PC_W'(1);
          end
        end
      end
      DONE: begin
        if (Start) begin
          ack_d = 1'b0;
          to_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      PgmCtr     <= '0;
      CycleCount <= '0;
      Running    <= 1'b0;
      Ack        <= 1'b0;
      Timeout    <= 1'b0;
    end else begin
      PgmCtr     <= pc_d;
      CycleCount <= cnt_d;
      Running    <= run_d;
      Ack        <= ack_d;
      Timeout    <= to_d;
    end
  end

endmodule
